// File: rtl/arm_mon_pkg.sv
// Shared types and constants for the ARM run monitor: run-state encoding and 7-seg glyphs.
package arm_mon_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } run_state_t;

  // Active-low gfedcba glyphs for decimal digits, indexed by digit value.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle. Only the low
// NUM_DIGITS decimal digits are kept, so the result is bin mod 10^NUM_DIGITS.
module bin2bcd_seq #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       sh;
  logic [4*NUM_DIGITS-1:0] acc;
  logic [4*NUM_DIGITS-1:0] adj;
  logic [4*NUM_DIGITS-1:0] acc_next;
  logic [CW-1:0]           cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] > 4'd4) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {adj[4*NUM_DIGITS-2:0], sh[DATA_W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sh   <= bin;
        acc  <= '0;
        cnt  <= CW'(DATA_W);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= acc_next;
        sh  <= {sh[DATA_W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/display7.sv
// Single-digit BCD to active-low 7-segment decoder; non-decimal codes blank the digit.
module display7
  import arm_mon_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/arm_run_monitor.sv
// Run control for the single-cycle ARM core: stalls it via clock enable on PC overrun, budget
// expiry or pass signature, and shows the last store on 7-seg digits through a BCD converter.
module arm_run_monitor #(
  parameter int DATA_W       = 32,
  parameter int NUM_DIGITS   = 4,
  parameter int PC_LIMIT     = 100,
  parameter int TARGET_ADDR  = 100,
  parameter int TARGET_DATA  = 7,
  parameter int CYCLE_BUDGET = 1024
) (
  input  logic                    clk_50Mhz,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       pc,
  input  logic                    mem_write,
  input  logic [DATA_W-1:0]       data_adr,
  input  logic [DATA_W-1:0]       write_data,
  output logic                    cpu_en,
  output logic                    halted,
  output logic                    led_success,
  output logic                    led_fail,
  output logic                    timeout,
  output logic [7*NUM_DIGITS-1:0] seg
);
  import arm_mon_pkg::*;

  localparam int AD = NUM_DIGITS - 1;
  localparam logic [DATA_W-1:0] PC_LIM      = DATA_W'(PC_LIMIT);
  localparam logic [DATA_W-1:0] TGT_ADR     = DATA_W'(TARGET_ADDR);
  localparam logic [DATA_W-1:0] TGT_DAT     = DATA_W'(TARGET_DATA);
  localparam logic [DATA_W-1:0] BUDGET_LAST = DATA_W'(CYCLE_BUDGET - 1);

  run_state_t        state, state_nxt;
  logic              timeout_nxt;
  logic [DATA_W-1:0] cycle_cnt;
  logic              pass_hit, budget_hit;

  assign pass_hit   = mem_write && (data_adr == TGT_ADR) && (write_data == TGT_DAT);
  assign budget_hit = (CYCLE_BUDGET != 0) && (cycle_cnt == BUDGET_LAST);

  always_comb begin
    state_nxt   = state;
    timeout_nxt = timeout;
    if (state == RUN) begin
      if (pass_hit) begin
        state_nxt = PASS;
      end else if ((pc > PC_LIM) || budget_hit) begin
        state_nxt   = FAIL;
        timeout_nxt = budget_hit;
      end
    end
  end

  always_ff @(posedge clk_50Mhz or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      timeout   <= 1'b0;
      cpu_en    <= 1'b1;
      cycle_cnt <= '0;
    end else begin
      state   <= state_nxt;
      timeout <= timeout_nxt;
      cpu_en  <= (state_nxt == RUN);
      if (state == RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign halted      = (state != RUN);
  assign led_success = (state == PASS);
  assign led_fail    = (state == FAIL);

  // Capture latch: last store wins; the converter reads it live, so a newer
  // store can never be displayed alongside an older store's data digit.
  logic [DATA_W-1:0] cap_adr, cap_dat;
  logic              pending, conv_active, phase;
  logic              start_addr, start_data, conv_start, conv_busy, conv_done;
  logic [DATA_W-1:0] conv_bin;
  logic [4*AD-1:0]   conv_bcd;
  logic [4*AD-1:0]   disp_adr;
  logic [3:0]        disp_dat;

  assign start_addr = pending && !conv_active;
  assign start_data = conv_done && !phase;
  assign conv_start = start_addr || start_data;
  assign conv_bin   = start_data ? cap_dat : cap_adr;

  always_ff @(posedge clk_50Mhz or posedge reset) begin
    if (reset) begin
      cap_adr <= '0;
      cap_dat <= '0;
      pending <= 1'b0;
    end else if (state == RUN && mem_write) begin
      cap_adr <= data_adr;
      cap_dat <= write_data;
      pending <= 1'b1;
    end else if (start_addr) begin
      pending <= 1'b0;
    end
  end

  // Two back-to-back conversions per update: address first, then data.
  always_ff @(posedge clk_50Mhz or posedge reset) begin
    if (reset) begin
      conv_active <= 1'b0;
      phase       <= 1'b0;
      disp_adr    <= '0;
      disp_dat    <= '0;
    end else if (start_addr) begin
      conv_active <= 1'b1;
      phase       <= 1'b0;
    end else if (conv_done) begin
      if (!phase) begin
        phase    <= 1'b1;
        disp_adr <= conv_bcd;
      end else begin
        conv_active <= 1'b0;
        disp_dat    <= conv_bcd[3:0];
      end
    end
  end

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(AD)
  ) u_bcd (
    .clk  (clk_50Mhz),
    .rst  (reset),
    .start(conv_start),
    .bin  (conv_bin),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  logic [4*NUM_DIGITS-1:0] digits;
  assign digits = {disp_dat, disp_adr};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    display7 u_d7 (
      .digit(digits[4*i +: 4]),
      .seg  (seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_arm_run_monitor.sv
// Directed bench for arm_run_monitor: run/pass/fail control, timeout budget and 7-seg display.
module tb_arm_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;

  logic        cpu_en, halted, led_success, led_fail, timeout;
  logic [27:0] seg;
  logic        cpu_en_b, halted_b, led_success_b, led_fail_b, timeout_b;
  logic [27:0] seg_b;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] SEG_ZERO = {4{7'h40}};
  localparam logic [27:0] SEG_7100 = {7'h78, 7'h79, 7'h40, 7'h40};
  localparam logic [27:0] SEG_9045 = {7'h10, 7'h40, 7'h19, 7'h12};
  localparam logic [27:0] SEG_5123 = {7'h12, 7'h79, 7'h24, 7'h30};

  always #5 clk = ~clk;

  arm_run_monitor dut (
    .clk_50Mhz(clk), .reset(reset), .pc(pc), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .cpu_en(cpu_en), .halted(halted), .led_success(led_success),
    .led_fail(led_fail), .timeout(timeout), .seg(seg)
  );

  arm_run_monitor #(.CYCLE_BUDGET(16)) dut_b (
    .clk_50Mhz(clk), .reset(reset), .pc(pc), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .cpu_en(cpu_en_b), .halted(halted_b), .led_success(led_success_b),
    .led_fail(led_fail_b), .timeout(timeout_b), .seg(seg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    mem_write = 1'b0;
    pc        = '0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write  = 1'b1;
    data_adr   = a;
    write_data = d;
    tick();
    mem_write  = 1'b0;
  endtask

  initial begin
    logic saw_5123;

    // 1: reset state, then pc ramp without stores
    do_reset();
    chk("rst_cpu_en", 64'(cpu_en), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_success", 64'(led_success), 64'd0);
    chk("rst_fail", 64'(led_fail), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_seg", 64'(seg), 64'(SEG_ZERO));
    for (int p = 0; p <= 96; p += 4) begin
      pc = 32'(p);
      tick();
    end
    chk("ramp_cpu_en", 64'(cpu_en), 64'd1);
    chk("ramp_leds", 64'({led_success, led_fail, halted}), 64'd0);
    chk("ramp_seg", 64'(seg), 64'(SEG_ZERO));

    // 2: pass signature at pc=40
    do_reset();
    pc = 32'd40;
    store(32'd100, 32'd7);
    chk("pass_success", 64'(led_success), 64'd1);
    chk("pass_cpu_en", 64'(cpu_en), 64'd0);
    chk("pass_halted", 64'(halted), 64'd1);
    repeat (68) tick();
    chk("pass_seg_7100", 64'(seg), 64'(SEG_7100));

    // 3: pc overrun
    do_reset();
    pc = 32'd100;
    tick();
    chk("pc_eq_limit_run", 64'(cpu_en), 64'd1);
    pc = 32'd104;
    tick();
    chk("pcfail_fail", 64'(led_fail), 64'd1);
    chk("pcfail_timeout", 64'(timeout), 64'd0);
    chk("pcfail_cpu_en", 64'(cpu_en), 64'd0);
    chk("pcfail_success", 64'(led_success), 64'd0);

    // 4: cycle budget of 16 on the second instance
    do_reset();
    repeat (15) tick();
    chk("budget_15_cpu_en", 64'(cpu_en_b), 64'd1);
    chk("budget_15_fail", 64'(led_fail_b), 64'd0);
    tick();
    chk("budget_16_fail", 64'(led_fail_b), 64'd1);
    chk("budget_16_timeout", 64'(timeout_b), 64'd1);
    chk("budget_16_cpu_en", 64'(cpu_en_b), 64'd0);
    chk("budget_main_run", 64'(cpu_en), 64'd1);

    // 5: pass and pc overrun in the same cycle
    do_reset();
    pc = 32'd104;
    store(32'd100, 32'd7);
    chk("tie_success", 64'(led_success), 64'd1);
    chk("tie_fail", 64'(led_fail), 64'd0);
    tick();
    chk("tie_fail_sticky", 64'(led_fail), 64'd0);

    // 6: last write wins, then async reset mid-conversion
    do_reset();
    store(32'd123, 32'd5);
    tick();
    tick();
    store(32'd45, 32'd9);
    saw_5123 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (seg === SEG_5123) saw_5123 = 1'b1;
      tick();
    end
    chk("lww_never_5123", 64'(saw_5123), 64'd0);
    chk("lww_seg_9045", 64'(seg), 64'(SEG_9045));
    store(32'd888, 32'd3);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_seg", 64'(seg), 64'(SEG_ZERO));
    tick();
    reset = 1'b0;
    repeat (80) tick();
    chk("abort_seg", 64'(seg), 64'(SEG_ZERO));
    chk("abort_cpu_en", 64'(cpu_en), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
